load_unit: RTL

Read-side companion to the store byte-enable logic in the MEM stage. It accepts one load request at a time (address, funct3), issues bus-word-aligned reads to data memory over a valid/ready request channel, and captures the response. It extracts and sign- or zero-extends the addressed byte, half, word or doubleword and returns the result to writeback. Optionally, a load that straddles a bus-word boundary is split into two beats and merged.

---
 rtl/load_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// Load unit: issues bus-word-aligned reads, then extracts and sign/zero-extends the addressed data.
// Optional LOAD_MISALIGN_SPLIT_EN: misaligned loads are serviced, and bus-word crossers are split into two beats.
module load_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            LoadReqM,
  output logic            LoadReadyM,
  input  logic [XLEN-1:0] addrM,
  input  logic [2:0]      funct3M,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            load_fault
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE,
    FAULT,
    REQ0,
    RESP0,
    REQ1,
    RESP1,
    DONE
  } state_t;

  state_t          state_q;
  logic            mem_req_valid_q;
  logic [XLEN-1:0] mem_addr_q;
  logic            load_valid_q;
  logic [XLEN-1:0] load_data_q;
  logic            load_fault_q;
  logic [OW-1:0]   offset_q;
  logic [2:0]      funct3_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] beat0_q;
  logic            crossing_q;
  logic            crossing;
`endif

  logic [3:0] sizeBytes;
  logic [3:0] offsetW;
  logic       illegal;
  logic       misaligned;
  logic       reqFault;

  // Request decode is evaluated on the live inputs so the accept cycle can pick the next state.
  always_comb begin
    sizeBytes  = 4'd1 << funct3M[1:0];
    offsetW    = 4'(addrM[OW-1:0]);
    illegal    = (funct3M == 3'b111) ||
                 ((XLEN == 32) && ((funct3M == 3'b011) || (funct3M == 3'b110)));
    misaligned = |(offsetW & (sizeBytes - 4'd1));
`ifdef LOAD_MISALIGN_SPLIT_EN
    crossing   = (5'(offsetW) + 5'(sizeBytes)) > 5'(NB);
    reqFault   = illegal;
`else
    reqFault   = illegal | misaligned;
`endif
  end

  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] pair,
                                               input logic [OW-1:0]     off,
                                               input logic [2:0]        f3);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] res;
    s = XLEN'(pair >> {off, 3'b000});
    case (f3)
      3'b000:  res = XLEN'(signed'(s[7:0]));
      3'b001:  res = XLEN'(signed'(s[15:0]));
      3'b010:  res = XLEN'(signed'(s[31:0]));
      3'b100:  res = XLEN'(s[7:0]);
      3'b101:  res = XLEN'(s[15:0]);
      3'b110:  res = XLEN'(s[31:0]);
      default: res = s;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      load_valid_q    <= 1'b0;
      load_data_q     <= '0;
      load_fault_q    <= 1'b0;
      offset_q        <= '0;
      funct3_q        <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      beat0_q         <= '0;
      crossing_q      <= 1'b0;
`endif
    end else begin
      load_valid_q <= 1'b0;
      load_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LoadReqM) begin
            offset_q <= addrM[OW-1:0];
            funct3_q <= funct3M;
            if (reqFault) begin
              state_q      <= FAULT;
              load_valid_q <= 1'b1;
              load_fault_q <= 1'b1;
              load_data_q  <= '0;
            end else begin
              state_q         <= REQ0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {addrM[XLEN-1:OW], {OW{1'b0}}};
`ifdef LOAD_MISALIGN_SPLIT_EN
              crossing_q      <= crossing;
`endif
            end
          end
        end
        FAULT: state_q <= IDLE;
        REQ0: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= RESP0;
          end
        end
        RESP0: begin
          if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
            if (crossing_q) begin
              beat0_q         <= mem_rdata;
              mem_addr_q      <= mem_addr_q + XLEN'(NB);
              mem_req_valid_q <= 1'b1;
              state_q         <= REQ1;
            end else begin
              load_data_q  <= extract({{XLEN{1'b0}}, mem_rdata}, offset_q, funct3_q);
              load_valid_q <= 1'b1;
              state_q      <= DONE;
            end
`else
            load_data_q  <= extract({{XLEN{1'b0}}, mem_rdata}, offset_q, funct3_q);
            load_valid_q <= 1'b1;
            state_q      <= DONE;
`endif
          end
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        // Second beat fetches the next bus word; the address add wraps naturally.
        REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= RESP1;
          end
        end
        RESP1: begin
          if (mem_rvalid) begin
            load_data_q  <= extract({mem_rdata, beat0_q}, offset_q, funct3_q);
            load_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LoadReadyM    = (state_q == IDLE);
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign load_valid    = load_valid_q;
  assign load_data     = load_data_q;
  assign load_fault    = load_fault_q;

endmodule
